// File: rtl/fp_pkg.sv
// Shared constants and types for the single-precision divider.
// Field widths, exponent bias, canonical NaN and the control state encoding.
package fp_pkg;

   localparam int unsigned BIAS  = 127;
   localparam int unsigned EXP_W = 8;
   localparam int unsigned MAN_W = 23;
   // Quotient width: one integer bit plus MAN_W+1 fractional bits.
   localparam int unsigned Q_W   = MAN_W + 2;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp32_t;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StDiv  = 2'd1,
      StNorm = 2'd2
   } state_t;

endpackage

// File: rtl/mantissa_divider.sv
// Restoring shift-subtract divider for 24-bit significands, one quotient bit per clock.
// Produces floor(m1 * 2^24 / m2) after Q_W iterations; valid marks the final iteration cycle.
module mantissa_divider
   import fp_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [MAN_W:0]   m1,
   input  logic [MAN_W:0]   m2,
   output logic [Q_W-1:0]   q,
   output logic             valid
);

   localparam logic [4:0] CNT_INIT = 5'(Q_W - 1);

   logic [MAN_W+2:0] r_q, r_d;
   logic [MAN_W:0]   div_q;
   logic [Q_W-1:0]   q_q;
   logic [4:0]       cnt_q;
   logic             run_q;
   logic             ge;
   logic [MAN_W+2:0] rem;

   always_comb begin
      ge  = r_q >= {2'b00, div_q};
      rem = ge ? (r_q - {2'b00, div_q}) : r_q;
      // rem < m2 < 2^24, so the left shift never drops a set bit.
      r_d = {rem[MAN_W+1:0], 1'b0};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q   <= '0;
         div_q <= '0;
         q_q   <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start) begin
         r_q   <= {2'b00, m1};
         div_q <= m2;
         q_q   <= '0;
         cnt_q <= CNT_INIT;
         run_q <= 1'b1;
      end else if (run_q) begin
         r_q <= r_d;
         q_q <= {q_q[Q_W-2:0], ge};
         if (cnt_q == 5'd0) begin
            run_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q - 5'd1;
         end
      end
   end

   assign q     = q_q;
   assign valid = run_q && (cnt_q == 5'd0);

endmodule

// File: rtl/fp_divider.sv
// Iterative IEEE-754 single-precision divider with truncated result and fixed 26-cycle latency.
// Handles sign, exponent, zero/denormal flush, overflow/underflow and normalisation around the loop.
module fp_divider
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   output logic [31:0] out,
   output logic        busy,
   output logic        done
);

   localparam logic signed [9:0] BIAS_S = 10'(BIAS);

   fp32_t a, b;
   assign a = in1;
   assign b = in2;

   state_t state_q, state_d;

   logic               sign_q;
   logic signed [9:0]  exp_q;
   logic               z1_q, z2_q;
   logic [31:0]        out_q;
   logic               done_q;
   logic               accept;
   logic [Q_W-1:0]     q;
   logic               q_valid;
   logic signed [9:0]  exp_n;
   logic [MAN_W-1:0]   man_n;
   logic [31:0]        result;

   assign accept = start && (state_q == StIdle);

   mantissa_divider u_mdiv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept),
      .m1    ({1'b1, a.man}),
      .m2    ({1'b1, b.man}),
      .q     (q),
      .valid (q_valid)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start)   state_d = StDiv;
         StDiv:   if (q_valid) state_d = StNorm;
         StNorm:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Quotient lies in (2^23, 2^25): the top bit selects the normalisation shift.
   always_comb begin
      if (q[Q_W-1]) begin
         exp_n = exp_q + BIAS_S;
         man_n = q[MAN_W:1];
      end else begin
         exp_n = exp_q + BIAS_S - 10'sd1;
         man_n = q[MAN_W-1:0];
      end

      if (z1_q && z2_q) begin
         result = QNAN;
      end else if (z2_q) begin
         result = {sign_q, 8'hFF, 23'h0};
      end else if (z1_q) begin
         result = {sign_q, 31'h0};
      end else if (exp_n >= 10'sd255) begin
         result = {sign_q, 8'hFF, 23'h0};
      end else if (exp_n <= 10'sd0) begin
         result = {sign_q, 31'h0};
      end else begin
         result = {sign_q, exp_n[EXP_W-1:0], man_n};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         z1_q    <= 1'b0;
         z2_q    <= 1'b0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == StNorm);
         if (accept) begin
            sign_q <= a.sign ^ b.sign;
            exp_q  <= 10'({2'b00, a.exp}) - 10'({2'b00, b.exp});
            z1_q   <= (a.exp == '0);
            z2_q   <= (b.exp == '0);
         end
         if (state_q == StNorm) begin
            out_q <= result;
         end
      end
   end

   assign out  = out_q;
   assign busy = (state_q != StIdle);
   assign done = done_q;

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: expected quotients queued at issue, checked on each done pulse.
// Covers directed values, special cases, exponent range, handshake, reset abort and random operands.
module tb_fp_divider;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] in1 = '0;
   logic [31:0] in2 = '0;
   logic [31:0] out;
   logic        busy;
   logic        done;

   int unsigned n_checks = 0;
   int unsigned n_pass = 0;
   int          cyc = 0;
   logic [31:0] exp_fifo[$];
   int          start_fifo[$];

   fp_divider dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .in1   (in1),
      .in2   (in2),
      .out   (out),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, want);
   endtask

   // Reference quotient from a wide integer division of the significands.
   function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
      logic        s;
      logic [63:0] num, den, qq;
      logic [22:0] man;
      int          e;
      s   = x[31] ^ y[31];
      num = {40'd0, 1'b1, x[22:0]} << 24;
      den = {40'd0, 1'b1, y[22:0]};
      qq  = num / den;
      if (qq[24]) begin
         man = qq[23:1];
         e   = int'(x[30:23]) - int'(y[30:23]) + 127;
      end else begin
         man = qq[22:0];
         e   = int'(x[30:23]) - int'(y[30:23]) + 126;
      end
      if (x[30:23] == 8'd0 && y[30:23] == 8'd0) return 32'h7FC0_0000;
      if (y[30:23] == 8'd0) return {s, 8'hFF, 23'h0};
      if (x[30:23] == 8'd0) return {s, 31'h0};
      if (e >= 255) return {s, 8'hFF, 23'h0};
      if (e <= 0) return {s, 31'h0};
      return {s, e[7:0], man};
   endfunction

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_fifo.size() == 0) begin
            check_eq("spurious_done", 32'(done), 32'd0);
         end else begin
            check_eq("result", out, exp_fifo.pop_front());
            check_eq("latency", 32'(cyc - start_fifo.pop_front()), 32'd26);
         end
      end
   end

   // Inputs are scrambled after capture so any late sampling shows up as a wrong result.
   task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] want);
      in1   = x;
      in2   = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      exp_fifo.push_back(want);
      start_fifo.push_back(cyc);
      in1 = $urandom;
      in2 = $urandom;
   endtask

   task automatic wait_done();
      bit got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = done;
      end
      if (!got) check_eq("timeout", 32'd0, 32'd1);
   endtask

   task automatic run_one(input logic [31:0] x, input logic [31:0] y, input logic [31:0] want);
      issue(x, y, want);
      check_eq("busy_high", 32'(busy), 32'd1);
      wait_done();
      check_eq("busy_low_at_done", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] ra, rb;

      #2;
      check_eq("rst_out", out, 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_one(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
      run_one(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA);
      run_one(32'hC100_0000, 32'h3F00_0000, 32'hC180_0000);
      run_one(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000);
      run_one(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000);
      run_one(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000);
      run_one(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000);
      run_one(32'h0080_0000, 32'h7F00_0000, 32'h0000_0000);

      // Extra start pulses while busy must not disturb the running division.
      issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
      repeat (4) @(posedge clk);
      #1;
      in1 = 32'h3F80_0000; in2 = 32'h4040_0000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      in1 = 32'hC100_0000; in2 = 32'h3F00_0000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done();
      @(posedge clk);
      #1;

      // Back-to-back: second start is presented during the done cycle.
      issue(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA);
      wait_done();
      issue(32'hC100_0000, 32'h3F00_0000, 32'hC180_0000);
      wait_done();
      @(posedge clk);
      #1;

      // Reset mid-division aborts and clears the result register.
      issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_eq("abort_out", out, 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      exp_fifo.delete();
      start_fifo.delete();
      repeat (3) begin
         @(negedge clk);
         check_eq("abort_done", 32'(done), 32'd0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      run_one(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA);

      for (int k = 0; k < 8; k++) begin
         ra = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
         rb = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
         run_one(ra, rb, ref_div(ra, rb));
      end

      check_eq("scoreboard_drained", 32'(exp_fifo.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
